uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Sequencer and supervisor for the UART Rx core. Enables the core and watches its one-hot state.
//   Recovers the core from stuck or illegal states by pulsing its reset.
//   Buffers each received byte and its error flags onto a valid/ready stream.
//   Detects inter-frame idle gaps.
//   Sits between the Rx core (FSM + shift register) and the control/FIFO logic.
// PARAMETERS
//   TICKS_PER_BIT  16  acq_sig_i ticks per bit period
//   GAP_BITS       3   idle bit periods in INTERVAL that end a frame (1..15)
//   WDT_BITS       12  bit periods without bit_synch_i before watchdog fires (2..255)
// PORTS
//   clk           in   1  system clock
//   rst           in   1  asynchronous, active-low reset
//   rx_enable_i   in   1  receiver enable from control register
//   state_i       in   5  Rx FSM state, one-hot: INTERVAL=00001 START=00010 DATA=00100 PARITY=01000 STOP=10000
//   bit_synch_i   in   1  end-of-bit pulse from Rx shift register
//   acq_sig_i     in   1  16x-baud acquisition tick, 1 clk wide
//   byte_valid_i  in   1  1-clk pulse: byte complete
//   byte_data_i   in   8  received byte, valid with byte_valid_i
//   parity_err_i  in   1  parity error, valid with byte_valid_i
//   stop_err_i    in   1  stop-bit error, valid with byte_valid_i
//   core_en_o     out  1  Rx core enable
//   core_rst_n_o  out  1  active-low Rx core reset, used for recovery
//   m_data_o      out  8  buffered byte
//   m_err_o       out  2  {stop_err, parity_err} of buffered byte
//   m_valid_o     out  1  buffer holds a byte
//   m_ready_i     in   1  downstream accepts; a transfer occurs when m_valid_o & m_ready_i
//   frame_end_o   out  1  1-clk pulse: idle gap reached after >=1 byte
//   overrun_o     out  1  sticky: byte lost because buffer was full
//   wdt_fault_o   out  1  sticky: recovery performed
//   clr_i         in   1  clears overrun_o and wdt_fault_o
// BEHAVIOUR
//   Reset values:
//   - core_en_o=0, core_rst_n_o=1, m_data_o=0, m_err_o=0, m_valid_o=0.
//   - frame_end_o=0, overrun_o=0, wdt_fault_o=0.
//   - Controller state OFF; all counters 0.
//   All outputs are registered.
//   States: OFF, IDLE, ACTIVE, GAP, RECOVER.
//   - OFF: core_en_o=0. Goes to IDLE when rx_enable_i=1; core_en_o=1 from the next clk.
//   - rx_enable_i=0 in any state except RECOVER -> OFF next clk.
//       The buffered byte is kept. Counters clear.
//   - IDLE: state_i!=INTERVAL -> ACTIVE.
//   - ACTIVE: state_i==INTERVAL -> GAP; gap counter clears.
//   - GAP: counts acq_sig_i ticks.
//       state_i!=INTERVAL -> ACTIVE.
//       Count reaches GAP_BITS*TICKS_PER_BIT -> IDLE, with frame_end_o=1 for 1 clk.
//   - Illegal state_i (not one-hot, incl. 0) in IDLE, ACTIVE or GAP -> RECOVER next clk.
//   - RECOVER: core_rst_n_o=0 for exactly 2 clk, then 1.
//       Then goes to IDLE, or to OFF if rx_enable_i=0.
//       wdt_fault_o set on entry. byte_valid_i is ignored.
//   Output buffer (1 entry):
//   - byte_valid_i with buffer empty, or with m_ready_i=1 in the same clk: load data/err; m_valid_o=1 next clk.
//   - byte_valid_i with m_valid_o=1 and m_ready_i=0: byte dropped, overrun_o=1, buffer unchanged.
//   - m_ready_i with no new byte: m_valid_o=0 next clk.
//   - Errored bytes are delivered, not dropped.
//   clr_i has priority under set: clr_i and a set event in the same clk leave the flag 1.
//   Counters saturate and never wrap. Widths are sized by $clog2 of their maximum value.
// CONFIGURATION
//   UART_RX_WATCHDOG_EN defined:
//   - In ACTIVE, a timeout counter counts acq_sig_i ticks and clears on each bit_synch_i.
//   - Reaching WDT_BITS*TICKS_PER_BIT -> RECOVER.
//   UART_RX_WATCHDOG_EN undefined:
//   - No timeout counter. RECOVER is entered only on an illegal state_i.
// TESTING
//   1 Enable, bytes 0x55 then 0xA3, m_ready_i=1, then idle 3 bit times -> two beats, m_err_o=0;
//     one frame_end_o pulse 48 ticks after state_i returns to INTERVAL.
//   2 m_ready_i=0, three bytes received -> m_data_o holds byte 1; overrun_o=1 at byte 2;
//     clr_i clears overrun_o; byte 3 also dropped.
//   3 byte_valid_i and m_ready_i in the same clk with buffer full -> old byte transferred;
//     new byte loaded; m_valid_o stays 1; no overrun.
//   4 WATCHDOG_EN: state_i held DATA with no bit_synch_i for 192 ticks -> core_rst_n_o low 2 clk;
//     wdt_fault_o=1; state IDLE. Undefined: no reset.
//   5 state_i=00110 while ACTIVE -> RECOVER next clk, core_rst_n_o low 2 clk.
//     rx_enable_i=0 mid-byte -> core_en_o=0 next clk, buffered byte still readable.
//   6 parity_err_i=1 with byte 0x7E -> m_data_o=0x7E, m_err_o=2'b01.
//     Async reset asserted mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Sequencer/supervisor for the UART Rx core: enable, recovery reset, 1-entry byte buffer, idle-gap detect.
// Define UART_RX_WATCHDOG_EN to add the missing-bit_synch timeout in ACTIVE.
module uart_rx_ctrl #(
    parameter int TICKS_PER_BIT = 16,
    parameter int GAP_BITS      = 3,
    parameter int WDT_BITS      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enable_i,
    input  logic [4:0] state_i,
    input  logic       bit_synch_i,
    input  logic       acq_sig_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic       parity_err_i,
    input  logic       stop_err_i,
    output logic       core_en_o,
    output logic       core_rst_n_o,
    output logic [7:0] m_data_o,
    output logic [1:0] m_err_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       frame_end_o,
    output logic       overrun_o,
    output logic       wdt_fault_o,
    input  logic       clr_i
);
    localparam logic [4:0] ST_INTERVAL = 5'b00001;
    localparam int GAP_MAX = GAP_BITS * TICKS_PER_BIT;
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_TOP  = GW'(GAP_MAX);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

    typedef enum logic [2:0] {OFF, IDLE, ACTIVE, GAP, RECOVER} ctrl_t;

    ctrl_t          state, state_nx;
    logic [GW-1:0]  gap_cnt;
    logic           rec_cnt;
    logic           seen_byte;
    logic           frame_end_nx;
    logic           illegal, gap_hit, wdt_hit;
    logic           byte_in, accept, overrun_set, fault_set;

    assign illegal = !$onehot(state_i);
    assign gap_hit = acq_sig_i && (gap_cnt == GAP_LAST);

`ifdef UART_RX_WATCHDOG_EN
    localparam int WDT_MAX = WDT_BITS * TICKS_PER_BIT;
    localparam int WW = $clog2(WDT_MAX + 1);
    localparam logic [WW-1:0] WDT_TOP  = WW'(WDT_MAX);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_MAX - 1);
    logic [WW-1:0] wdt_cnt;

    assign wdt_hit = acq_sig_i && !bit_synch_i && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdt_cnt <= '0;
        else if (state != ACTIVE || bit_synch_i)
            wdt_cnt <= '0;
        else if (acq_sig_i && wdt_cnt != WDT_TOP)
            wdt_cnt <= wdt_cnt + 1'b1;
    end
`else
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        frame_end_nx = 1'b0;
        case (state)
            OFF:     if (rx_enable_i) state_nx = IDLE;
            RECOVER: if (rec_cnt) state_nx = rx_enable_i ? IDLE : OFF;
            default: begin
                if (!rx_enable_i)
                    state_nx = OFF;
                else if (illegal)
                    state_nx = RECOVER;
                else begin
                    case (state)
                        IDLE:   if (state_i != ST_INTERVAL) state_nx = ACTIVE;
                        ACTIVE: begin
                            if (state_i == ST_INTERVAL) state_nx = GAP;
                            else if (wdt_hit)           state_nx = RECOVER;
                        end
                        GAP: begin
                            if (state_i != ST_INTERVAL)
                                state_nx = ACTIVE;
                            else if (gap_hit) begin
                                state_nx     = IDLE;
                                frame_end_nx = seen_byte;
                            end
                        end
                        default: state_nx = OFF;
                    endcase
                end
            end
        endcase
    end

    // Bytes arriving while the core is being reset are not trusted.
    assign byte_in     = byte_valid_i && (state != RECOVER);
    assign accept      = byte_in && (!m_valid_o || m_ready_i);
    assign overrun_set = byte_in && m_valid_o && !m_ready_i;
    assign fault_set   = (state_nx == RECOVER) && (state != RECOVER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= OFF;
            core_en_o    <= 1'b0;
            core_rst_n_o <= 1'b1;
            frame_end_o  <= 1'b0;
            gap_cnt      <= '0;
            rec_cnt      <= 1'b0;
            seen_byte    <= 1'b0;
            m_data_o     <= '0;
            m_err_o      <= '0;
            m_valid_o    <= 1'b0;
            overrun_o    <= 1'b0;
            wdt_fault_o  <= 1'b0;
        end else begin
            state        <= state_nx;
            core_en_o    <= (state_nx != OFF);
            core_rst_n_o <= (state_nx != RECOVER);
            frame_end_o  <= frame_end_nx;
            rec_cnt      <= (state == RECOVER) && !rec_cnt;

            if (state != GAP)
                gap_cnt <= '0;
            else if (acq_sig_i && gap_cnt != GAP_TOP)
                gap_cnt <= gap_cnt + 1'b1;

            if (state_nx == OFF || frame_end_nx)
                seen_byte <= 1'b0;
            else if (byte_in)
                seen_byte <= 1'b1;

            if (accept) begin
                m_data_o  <= byte_data_i;
                m_err_o   <= {stop_err_i, parity_err_i};
                m_valid_o <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            overrun_o   <= overrun_set | (overrun_o & ~clr_i);
            wdt_fault_o <= fault_set   | (wdt_fault_o & ~clr_i);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected beats are queued by stimulus, popped by a monitor.
module tb_uart_rx_ctrl;
    localparam logic [4:0] INTERVAL = 5'b00001, START = 5'b00010, DATA = 5'b00100, STOP = 5'b10000;

    logic       clk = 1'b0, rst = 1'b0;
    logic       rx_enable_i = 0, bit_synch_i = 0, acq_sig_i = 0, byte_valid_i = 0;
    logic [4:0] state_i = INTERVAL;
    logic [7:0] byte_data_i = 0;
    logic       parity_err_i = 0, stop_err_i = 0, m_ready_i = 0, clr_i = 0;
    logic       core_en_o, core_rst_n_o, m_valid_o, frame_end_o, overrun_o, wdt_fault_o;
    logic [7:0] m_data_o;
    logic [1:0] m_err_o;

    int checks = 0, failures = 0;
    logic [9:0] exp_q[$];

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst), .rx_enable_i(rx_enable_i), .state_i(state_i),
        .bit_synch_i(bit_synch_i), .acq_sig_i(acq_sig_i), .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i), .parity_err_i(parity_err_i), .stop_err_i(stop_err_i),
        .core_en_o(core_en_o), .core_rst_n_o(core_rst_n_o), .m_data_o(m_data_o),
        .m_err_o(m_err_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .frame_end_o(frame_end_o), .overrun_o(overrun_o), .wdt_fault_o(wdt_fault_o),
        .clr_i(clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake beat is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected actual=%0h expected=none", {m_err_o, m_data_o});
            end else begin
                chk("beat", {22'd0, m_err_o, m_data_o}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic se, input bit push);
        state_i = START; cyc();
        state_i = DATA; bit_synch_i = 1; cyc();
        bit_synch_i = 0; state_i = STOP; cyc();
        byte_data_i = d; parity_err_i = pe; stop_err_i = se; byte_valid_i = 1;
        if (push) exp_q.push_back({se, pe, d});
        cyc();
        byte_valid_i = 0; parity_err_i = 0; stop_err_i = 0;
        state_i = INTERVAL; cyc();
    endtask

    task automatic count_rst_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            cyc();
            if (!core_rst_n_o) lows++;
        end
    endtask

    initial begin
        int first_fe, fe_cnt, lows;

        // Reset state
        cyc(2);
        chk("rst_core_en", core_en_o, 0);
        chk("rst_core_rst_n", core_rst_n_o, 1);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_flags", {frame_end_o, overrun_o, wdt_fault_o}, 0);
        rst = 1; cyc();
        chk("off_no_enable", core_en_o, 0);
        rx_enable_i = 1; cyc();
        chk("enable_next_clk", core_en_o, 1);

        // Two bytes streamed, then a 3-bit idle gap
        m_ready_i = 1;
        send_byte(8'h55, 0, 0, 1);
        send_byte(8'hA3, 0, 0, 1);
        acq_sig_i = 1; first_fe = -1; fe_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            cyc();
            if (frame_end_o) begin
                fe_cnt++;
                if (first_fe < 0) first_fe = k;
            end
        end
        acq_sig_i = 0;
        chk("frame_end_count", fe_cnt, 1);
        chk("frame_end_latency", first_fe, 48);
        chk("t1_queue_drained", exp_q.size(), 0);

        // Errored byte is delivered with its flag
        send_byte(8'h7E, 1, 0, 1);
        send_byte(8'hC3, 0, 1, 1);
        chk("err_queue_drained", exp_q.size(), 0);

        // Overrun with stalled consumer
        m_ready_i = 0;
        send_byte(8'h11, 0, 0, 1);
        chk("ovr_clear_before", overrun_o, 0);
        send_byte(8'h22, 0, 0, 0);
        chk("ovr_set", overrun_o, 1);
        clr_i = 1; cyc(); clr_i = 0;
        chk("ovr_cleared", overrun_o, 0);
        send_byte(8'h33, 0, 0, 0);
        chk("ovr_set_again", overrun_o, 1);
        chk("ovr_holds_first", m_data_o, 8'h11);
        m_ready_i = 1; cyc(); m_ready_i = 0; cyc();
        chk("ovr_drained", m_valid_o, 0);
        // set wins over clear
        m_ready_i = 0;
        send_byte(8'h44, 0, 0, 1);
        byte_valid_i = 1; byte_data_i = 8'hEE; clr_i = 1; cyc();
        byte_valid_i = 0; clr_i = 1; cyc(0);
        chk("set_beats_clr", overrun_o, 1);
        cyc(); clr_i = 0;
        chk("clr_after", overrun_o, 0);

        // Simultaneous load and drain with buffer full
        byte_valid_i = 1; byte_data_i = 8'h66; m_ready_i = 1;
        exp_q.push_back({2'b00, 8'h66});
        cyc();
        byte_valid_i = 0; m_ready_i = 0;
        chk("pass_valid", m_valid_o, 1);
        chk("pass_data", m_data_o, 8'h66);
        chk("pass_no_ovr", overrun_o, 0);
        m_ready_i = 1; cyc(); m_ready_i = 0;
        chk("t3_queue_drained", exp_q.size(), 0);

        // Illegal one-hot from ACTIVE
        state_i = DATA; cyc(2);
        state_i = 5'b00110; cyc();
        state_i = INTERVAL;
        chk("illegal_rec_next", core_rst_n_o, 0);
        chk("illegal_fault", wdt_fault_o, 1);
        count_rst_low(6, lows);
        chk("illegal_rst_width", lows + 1, 2);
        chk("rec_core_en", core_en_o, 1);
        clr_i = 1; cyc(); clr_i = 0;
        chk("fault_cleared", wdt_fault_o, 0);

        // Disable mid-byte keeps the buffered byte
        send_byte(8'h5A, 0, 0, 1);
        state_i = DATA; cyc();
        rx_enable_i = 0; cyc();
        chk("dis_core_en", core_en_o, 0);
        chk("dis_keep_valid", m_valid_o, 1);
        chk("dis_keep_data", m_data_o, 8'h5A);
        m_ready_i = 1; cyc(); m_ready_i = 0;
        state_i = INTERVAL; rx_enable_i = 1; cyc(2);

        // Watchdog: DATA held, ticks, no bit_synch
        state_i = DATA; acq_sig_i = 1;
        count_rst_low(220, lows);
        acq_sig_i = 0; state_i = INTERVAL; cyc(2);
`ifdef UART_RX_WATCHDOG_EN
        chk("wdt_rst_width", lows, 2);
        chk("wdt_fault", wdt_fault_o, 1);
`else
        chk("wdt_rst_width", lows, 0);
        chk("wdt_fault", wdt_fault_o, 0);
`endif
        clr_i = 1; cyc(); clr_i = 0;

        // Async reset mid-frame
        m_ready_i = 0;
        send_byte(8'h99, 0, 1, 0);
        send_byte(8'h98, 0, 0, 0);
        state_i = DATA; cyc();
        chk("pre_rst_valid", {m_valid_o, overrun_o}, 2'b11);
        #3 rst = 0; exp_q.delete();
        #1;
        chk("arst_core", {core_en_o, core_rst_n_o}, 2'b01);
        chk("arst_buf", {m_valid_o, m_err_o, m_data_o}, 0);
        chk("arst_flags", {frame_end_o, overrun_o, wdt_fault_o}, 0);
        cyc(2); rst = 1; state_i = INTERVAL; cyc(2);
        chk("after_rst_off", core_en_o, 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
